// File: rtl/sipo_rx_shift_reg.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words MSB- or LSB-first and hands them
// to a consumer through a one-deep valid/ready holding register with a sticky overrun flag.
module sipo_rx_shift_reg #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_a,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             lsb_first,
   input  logic             frame_start,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic             busy,
   output logic [CNT_W-1:0] bit_cnt
);

   typedef enum logic [0:0] {StIdle, StCollect} state_e;

   state_e             state_q;
   logic               dir_q;
   logic [WIDTH-1:0]   shreg_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [WIDTH-1:0]   dout_q;
   logic               dout_valid_q;
   logic               overrun_q;
   logic               busy_q;

   logic               new_word;
   logic               dir_d;
   logic [WIDTH-1:0]   shreg_base;
   logic [WIDTH-1:0]   shreg_d;
   logic [CNT_W-1:0]   bit_idx;
   logic [CNT_W-1:0]   bit_cnt_d;
   logic               last_bit;
   logic               complete;
   logic               accept;
   logic               drop;

   // A bit taken in IDLE, or alongside frame_start, opens a fresh word and re-latches direction.
   always_comb begin
      new_word   = frame_start | (state_q == StIdle);
      dir_d      = new_word ? lsb_first : dir_q;
      shreg_base = frame_start ? '0 : shreg_q;
      shreg_d    = dir_d ? {sin, shreg_base[WIDTH-1:1]} : {shreg_base[WIDTH-2:0], sin};
      bit_idx    = new_word ? '0 : bit_cnt_q;
      last_bit   = (bit_idx == CNT_W'(WIDTH - 1));
      bit_cnt_d  = last_bit ? '0 : bit_idx + 1'b1;
      complete   = sin_valid & last_bit;
      accept     = complete & (~dout_valid_q | dout_ready);
      drop       = complete & ~accept;
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state_q      <= StIdle;
         dir_q        <= 1'b0;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         if (sin_valid) begin
            dir_q     <= dir_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= (bit_cnt_d != '0);
            state_q   <= last_bit ? StIdle : StCollect;
         end else if (frame_start) begin
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
         end

         // Completion may refill the holder on the same edge the consumer empties it.
         if (accept) begin
            dout_q       <= shreg_d;
            dout_valid_q <= 1'b1;
         end else if (dout_valid_q && dout_ready) begin
            dout_valid_q <= 1'b0;
         end

         if (drop) begin
            overrun_q <= 1'b1;
         end else if (ovr_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;
   assign bit_cnt    = bit_cnt_q;

   a_idle_cnt : assert property (@(posedge clk) disable iff (!rst_a)
      (state_q == StIdle) == (bit_cnt_q == '0));

   a_dout_stable : assert property (@(posedge clk) disable iff (!rst_a)
      (dout_valid_q && !dout_ready) |=> $stable(dout_q) && dout_valid_q);

endmodule

// File: tb/tb_sipo_rx_shift_reg.sv
// Directed self-checking bench for sipo_rx_shift_reg (WIDTH=8): assembly order, handshake,
// overrun, frame resync and asynchronous reset.
module tb_sipo_rx_shift_reg;

   logic       clk = 1'b0;
   logic       rst_a;
   logic       sin;
   logic       sin_valid;
   logic       lsb_first;
   logic       frame_start;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       overrun;
   logic       ovr_clr;
   logic       busy;
   logic [2:0] bit_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sipo_rx_shift_reg #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_a       (rst_a),
      .sin         (sin),
      .sin_valid   (sin_valid),
      .lsb_first   (lsb_first),
      .frame_start (frame_start),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .overrun     (overrun),
      .ovr_clr     (ovr_clr),
      .busy        (busy),
      .bit_cnt     (bit_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends w serially; MSB-first sends w[7] first, LSB-first sends w[0] first.
   task automatic send_word(input logic [7:0] w, input logic lsb, input logic fs_first,
                            input logic rdy_last, input logic clr_last);
      logic rdy_save;
      rdy_save = dout_ready;
      for (int i = 0; i < 8; i++) begin
         sin         = lsb ? w[i] : w[7-i];
         sin_valid   = 1'b1;
         lsb_first   = lsb;
         frame_start = fs_first && (i == 0);
         if (i == 7 && rdy_last) dout_ready = 1'b1;
         if (i == 7 && clr_last) ovr_clr = 1'b1;
         step();
      end
      sin_valid   = 1'b0;
      frame_start = 1'b0;
      ovr_clr     = 1'b0;
      dout_ready  = rdy_save;
   endtask

   task automatic test_reset();
      rst_a = 1'b0; sin = 1'b0; sin_valid = 1'b0; lsb_first = 1'b0;
      frame_start = 1'b0; dout_ready = 1'b0; ovr_clr = 1'b0;
      #12;
      checks++;
      if ({dout, dout_valid, overrun, busy, bit_cnt} !== 14'd0) begin
         failures++;
         $display("FAIL reset_state: got dout=%h v=%b ovr=%b busy=%b cnt=%0d, want all 0",
                  dout, dout_valid, overrun, busy, bit_cnt);
      end
      @(negedge clk);
      rst_a = 1'b1;
      step();
   endtask

   task automatic test_msb_first();
      logic [7:0] seq;
      seq = 8'b0000_1011;
      dout_ready = 1'b1;
      lsb_first  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sin = seq[7-i]; sin_valid = 1'b1;
         step();
         if (i == 6) begin
            checks++;
            if (bit_cnt !== 3'd7 || busy !== 1'b1 || dout_valid !== 1'b0) begin
               failures++;
               $display("FAIL msb_partial: got cnt=%0d busy=%b v=%b, want 7 1 0",
                        bit_cnt, busy, dout_valid);
            end
         end
      end
      sin_valid = 1'b0;
      checks++;
      if (dout !== 8'h0B || dout_valid !== 1'b1 || bit_cnt !== 3'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL msb_word: got dout=%h v=%b cnt=%0d busy=%b, want 0b 1 0 0",
                  dout, dout_valid, bit_cnt, busy);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] seq;
      seq = 8'b0000_1011;
      for (int run = 0; run < 2; run++) begin
         for (int i = 0; i < 8; i++) begin
            sin = seq[7-i]; sin_valid = 1'b1;
            lsb_first = (run == 1 && i >= 3) ? 1'b0 : 1'b1;
            step();
         end
         sin_valid = 1'b0;
         checks++;
         if (dout !== 8'hD0 || dout_valid !== 1'b1) begin
            failures++;
            $display("FAIL lsb_word run%0d: got dout=%h v=%b, want d0 1", run, dout, dout_valid);
         end
      end
   endtask

   task automatic test_overrun();
      dout_ready = 1'b1;
      step();
      checks++;
      if (dout_valid !== 1'b0 || dout !== 8'hD0) begin
         failures++;
         $display("FAIL consume: got v=%b dout=%h, want 0 d0", dout_valid, dout);
      end
      step();
      checks++;
      if (dout_valid !== 1'b0) begin
         failures++;
         $display("FAIL ready_when_empty: got v=%b, want 0", dout_valid);
      end
      dout_ready = 1'b0;
      send_word(8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dout !== 8'h0B || dout_valid !== 1'b1 || overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_drop: got dout=%h v=%b ovr=%b, want 0b 1 1",
                  dout, dout_valid, overrun);
      end
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0 || dout !== 8'h0B || dout_valid !== 1'b1) begin
         failures++;
         $display("FAIL ovr_clr: got ovr=%b dout=%h v=%b, want 0 0b 1", overrun, dout, dout_valid);
      end
      send_word(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (overrun !== 1'b1 || dout !== 8'h0B) begin
         failures++;
         $display("FAIL ovr_set_wins: got ovr=%b dout=%h, want 1 0b", overrun, dout);
      end
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      int drops;
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
      send_word(8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dout !== 8'h0B || dout_valid !== 1'b1 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first: got dout=%h v=%b ovr=%b, want 0b 1 0", dout, dout_valid, overrun);
      end
      w = 8'h55;
      drops = 0;
      for (int i = 0; i < 8; i++) begin
         sin = w[7-i]; sin_valid = 1'b1; lsb_first = 1'b0;
         dout_ready = (i == 7);
         step();
         if (dout_valid !== 1'b1) drops++;
      end
      sin_valid = 1'b0; dout_ready = 1'b0;
      checks++;
      if (dout !== 8'h55 || drops != 0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second: got dout=%h valid_drops=%0d ovr=%b, want 55 0 0",
                  dout, drops, overrun);
      end
   endtask

   task automatic test_frame_start();
      for (int i = 0; i < 3; i++) begin
         sin = 1'b1; sin_valid = 1'b1; lsb_first = 1'b0;
         step();
      end
      sin_valid = 1'b0;
      checks++;
      if (bit_cnt !== 3'd3 || busy !== 1'b1) begin
         failures++;
         $display("FAIL fs_partial: got cnt=%0d busy=%b, want 3 1", bit_cnt, busy);
      end
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      checks++;
      if (bit_cnt !== 3'd0 || busy !== 1'b0 || dout !== 8'h55 || dout_valid !== 1'b1) begin
         failures++;
         $display("FAIL fs_resync: got cnt=%0d busy=%b dout=%h v=%b, want 0 0 55 1",
                  bit_cnt, busy, dout, dout_valid);
      end
      dout_ready = 1'b1;
      send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dout !== 8'hA5 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL fs_word: got dout=%h v=%b ovr=%b, want a5 1 0", dout, dout_valid, overrun);
      end
      for (int i = 0; i < 5; i++) begin
         sin = 1'b1; sin_valid = 1'b1; lsb_first = 1'b0;
         step();
      end
      send_word(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (dout !== 8'hC3 || dout_valid !== 1'b1 || bit_cnt !== 3'd0) begin
         failures++;
         $display("FAIL fs_with_bit: got dout=%h v=%b cnt=%0d, want c3 1 0",
                  dout, dout_valid, bit_cnt);
      end
      dout_ready = 1'b0;
   endtask

   task automatic test_reset_mid_word();
      for (int i = 0; i < 5; i++) begin
         sin = 1'b1; sin_valid = 1'b1; lsb_first = 1'b0;
         step();
      end
      sin_valid = 1'b0;
      checks++;
      if (bit_cnt !== 3'd5 || dout_valid !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: got cnt=%0d v=%b, want 5 1", bit_cnt, dout_valid);
      end
      #2 rst_a = 1'b0;
      #1;
      checks++;
      if ({dout, dout_valid, overrun, busy, bit_cnt} !== 14'd0) begin
         failures++;
         $display("FAIL async_reset: got dout=%h v=%b ovr=%b busy=%b cnt=%0d, want all 0",
                  dout, dout_valid, overrun, busy, bit_cnt);
      end
      step();
      rst_a = 1'b1;
      step();
      send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dout !== 8'h3C || dout_valid !== 1'b1 || overrun !== 1'b0 || bit_cnt !== 3'd0) begin
         failures++;
         $display("FAIL post_reset_word: got dout=%h v=%b ovr=%b cnt=%0d, want 3c 1 0 0",
                  dout, dout_valid, overrun, bit_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_overrun();
      test_back_to_back();
      test_frame_start();
      test_reset_mid_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
